if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipeline. Sits directly upstream of the IF/ID pipeline register.
- Owns the PC and drives a variable-latency instruction memory over a req/ack handshake.
- Delivers {PC+4, instruction} to IF/ID, and inserts bubbles via Flush_o when no instruction is ready or a branch/jump redirect occurs.
- Buffers one returned instruction while the hazard unit stalls IF/ID.

Parameters:
RESET_PC  32'h0000_0000  PC value loaded on reset (low 2 bits must be 0)

Ports:
clk_i          input   1   clock, all state updates on rising edge
rst_i          input   1   synchronous active-high reset
Stall_i        input   1   hazard stall; IF/ID holds this cycle (same signal drives IF/ID Stall_i)
Branch_i       input   1   taken branch/jump resolved in ID; held high by ID while Stall_i is high
BranchAddr_i   input   32  redirect target; bits [1:0] ignored, treated as 0
imem_req_o     output  1   instruction memory request
imem_addr_o    output  32  request word address (byte address, [1:0]=0)
imem_ack_i     input   1   one-cycle completion, may arrive in the same cycle as req (zero-wait)
imem_data_i    input   32  instruction, valid when imem_ack_i=1
PC_o           output  32  PC+4 of the delivered instruction, to IF/ID PC_i
instruction_o  output  32  delivered instruction, to IF/ID instruction_i
Flush_o        output  1   bubble/flush request, to IF/ID Flush_i

Behaviour:
- State: pc[31:0], drain_addr[31:0], inst_buf[31:0], FSM {FETCH, HOLD, DRAIN}.
- Reset is synchronous: rst_i=1 at a clock edge sets pc=RESET_PC and state=FETCH, and clears inst_buf.
- While rst_i=1, outputs are forced regardless of state: imem_req_o=0, Flush_o=1, instruction_o=0, PC_o=pc+4.
- Memory handshake:
  - A request completes on a cycle with req&ack.
  - While waiting, req stays high and the address stays stable.
  - req high on the cycle after a completion is a new request; back-to-back requests give 1 instr/cycle with a zero-wait memory.
- A "deliver" cycle is one in which instruction_o is valid, Stall_i=0 and Branch_i=0. On a deliver cycle: Flush_o=0, PC_o=pc+4, pc<=pc+4, next state FETCH.
- FETCH:
  - Outputs: imem_req_o=1, imem_addr_o=pc.
  - If ack=1: instruction_o=imem_data_i.
    - With Stall_i=0: deliver.
    - With Stall_i=1: inst_buf<=imem_data_i, pc held, go to HOLD.
  - If ack=0: instruction_o=0. Flush_o=1 when Stall_i=0 (bubble); Flush_o=0 when Stall_i=1 (IF/ID holds). Stay in FETCH.
- HOLD:
  - Outputs: imem_req_o=0, instruction_o=inst_buf.
  - Stall_i=1: stay, Flush_o=0.
  - Stall_i=0: deliver.
- DRAIN:
  - Outputs: imem_req_o=1, imem_addr_o=drain_addr (the abandoned request), instruction_o=0.
  - Flush_o=1 when Stall_i=0.
  - On ack: data is discarded, go to FETCH (new request next cycle).
- Redirect: Branch_i is sampled only when Stall_i=0; it has priority over delivery. Flush_o=1 and pc<={BranchAddr_i[31:2],2'b00}. Next state depends on where the redirect lands:
  - FETCH, ack=0: drain_addr<=pc, go to DRAIN (outstanding request must finish).
  - FETCH, ack=1: data discarded, go to FETCH.
  - HOLD: inst_buf discarded, go to FETCH.
  - DRAIN: pc updated, stay in DRAIN (drain_addr unchanged).
- Branch_i=1 with Stall_i=1: ignored that cycle; pc and state follow the stall rules.
- pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- Latency: with a zero-wait memory, the instruction at pc appears on instruction_o in the same cycle the request is issued, and IF/ID captures it at the next edge.
- Memory shares rst_i; no ack is expected in the cycle after reset for a pre-reset request.

Test Plan:
1. Reset, then zero-wait memory (ack=req, data=addr^0xA5A5A5A5) for 4 cycles -> imem_addr_o 0,4,8,C; PC_o 4,8,C,10; Flush_o=0 throughout.
2. Memory with 2-cycle wait (ack on 3rd req cycle) -> Flush_o=1 for 2 cycles, then delivery with PC_o=4; imem_addr_o stable at 0 across all 3 cycles.
3. Ack of 0x8C220004 at pc=0x10 with Stall_i=1 for 3 cycles -> HOLD, imem_req_o=0, instruction_o=0x8C220004 held, pc unchanged; after Stall_i drops: deliver with PC_o=0x14, next req addr 0x14.
4. Branch_i=1, BranchAddr_i=0x43 during FETCH with req at 0x20 pending (ack 2 cycles later, data 0xDEADBEEF) -> Flush_o=1; imem_addr_o stays 0x20 until ack; 0xDEADBEEF never appears on instruction_o; next request at 0x40.
5. Branch_i=1 with Stall_i=1 for 2 cycles, then Stall_i=0 -> no redirect during stall; redirect to the target taken on the first unstalled cycle with Flush_o=1.
6. RESET_PC=0xFFFF_FFFC, zero-wait memory -> first delivery PC_o=0x0, next imem_addr_o=0x0; assert rst_i mid-wait -> imem_req_o=0 and Flush_o=1 during reset, restart fetch at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage that owns the PC, drives a req/ack instruction memory and feeds IF/ID
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        Stall_i,
  input  logic        Branch_i,
  input  logic [31:0] BranchAddr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] PC_o,
  output logic [31:0] instruction_o,
  output logic        Flush_o
);
  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, pc_inc, target, drain_addr, drain_n, inst_buf, buf_n;
  logic fetch, hold, drain, valid, deliver, redirect;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drain_addr <= '0;
      inst_buf   <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      drain_addr <= drain_n;
      inst_buf   <= buf_n;
    end
  always_comb begin
    fetch         = state == FETCH;
    hold          = state == HOLD;
    drain         = !(fetch || hold);
    pc_inc        = pc + 32'd4;
    target        = BranchAddr_i & ~32'd3;
    valid         = hold || (fetch && imem_ack_i);
    redirect      = Branch_i && !Stall_i;
    deliver       = valid && !Stall_i && !Branch_i;
    imem_req_o    = !rst_i && !hold;
    imem_addr_o   = drain ? drain_addr : pc;
    instruction_o = rst_i ? '0 : hold ? inst_buf : (fetch && imem_ack_i) ? imem_data_i : '0;
    Flush_o       = rst_i || (!Stall_i && !deliver);
    PC_o          = pc_inc;
    pc_n          = redirect ? target : deliver ? pc_inc : pc;
    drain_n       = (redirect && fetch && !imem_ack_i) ? pc : drain_addr;
    buf_n         = (fetch && imem_ack_i && Stall_i) ? imem_data_i : inst_buf;
    state_n       = redirect ? ((hold || imem_ack_i) ? FETCH : DRAIN)
                  : fetch    ? ((imem_ack_i && Stall_i) ? HOLD : FETCH)
                  : hold     ? (Stall_i ? HOLD : FETCH)
                  : (imem_ack_i ? FETCH : DRAIN);
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized check of if_fetch_unit against a request-bookkeeping reference model
module tb_if_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, stall, branch, ack;
  logic [31:0] baddr, data;
  logic req, flush;
  logic [31:0] addr, pc_o, inst;
  logic w_rst, w_zero, w_req, w_ack, w_flush;
  logic [31:0] w_addr, w_data, w_pc, w_inst;
  logic w_stall, w_branch;
  logic [31:0] w_baddr;
  int n_chk = 0, n_pass = 0;
  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst), .Stall_i(stall), .Branch_i(branch), .BranchAddr_i(baddr),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack), .imem_data_i(data),
    .PC_o(pc_o), .instruction_o(inst), .Flush_o(flush)
  );
  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk_i(clk), .rst_i(w_rst), .Stall_i(w_stall), .Branch_i(w_branch), .BranchAddr_i(w_baddr),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_ack_i(w_ack), .imem_data_i(w_data),
    .PC_o(w_pc), .instruction_o(w_inst), .Flush_o(w_flush)
  );
  assign w_ack  = w_req && w_zero;
  assign w_data = w_addr ^ 32'hA5A5_A5A5;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  logic [31:0] m_pc, m_buf, m_abn;
  logic m_has_buf, m_has_abn;
  logic e_req, e_flush, done, fresh, avail, redir, dlv;
  logic [31:0] e_addr, e_inst;
  initial begin
    rst = 1; stall = 0; branch = 0; baddr = 0; ack = 0; data = 0;
    w_rst = 1; w_zero = 1; w_stall = 0; w_branch = 0; w_baddr = 0;
    m_pc = 0; m_buf = 0; m_abn = 0; m_has_buf = 0; m_has_abn = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      rst = cyc < 2 || $urandom_range(199) == 0;
      if (!(branch && stall)) begin
        branch = cyc >= 20 && $urandom_range(99) < 12;
        baddr = ($urandom_range(3) == 0) ? (32'hFFFF_FFFC | $urandom_range(3)) : $urandom;
      end
      stall = cyc >= 20 && $urandom_range(99) < 30;
      #1;
      ack = req && (cyc < 200 || (cyc >= 1500 && cyc < 1800) || $urandom_range(99) < 40);
      data = $urandom;
      #1;
      e_req  = !rst && !m_has_buf;
      e_addr = m_has_abn ? m_abn : m_pc;
      done   = ack && e_req;
      fresh  = done && !m_has_abn;
      avail  = !rst && (m_has_buf || fresh);
      e_inst = !avail ? 32'h0 : m_has_buf ? m_buf : data;
      redir  = branch && !stall;
      dlv    = avail && !stall && !branch;
      e_flush = rst || (!stall && !dlv);
      if (cyc > 0) begin
        chk("req", {31'b0, req}, {31'b0, e_req});
        if (e_req) chk("addr", addr, e_addr);
        chk("inst", inst, e_inst);
        chk("flush", {31'b0, flush}, {31'b0, e_flush});
        chk("pc_o", pc_o, m_pc + 32'd4);
      end
      if (rst) begin
        m_pc = 0; m_has_buf = 0; m_has_abn = 0;
      end else if (redir) begin
        if (!m_has_buf && !m_has_abn && !done) begin
          m_has_abn = 1;
          m_abn = m_pc;
        end else if (m_has_abn && done) m_has_abn = 0;
        m_has_buf = 0;
        m_pc = {baddr[31:2], 2'b00};
      end else if (dlv) begin
        m_pc = m_pc + 32'd4;
        m_has_buf = 0;
      end else begin
        if (m_has_abn && done) m_has_abn = 0;
        if (fresh && stall) begin
          m_has_buf = 1;
          m_buf = data;
        end
      end
    end
    @(posedge clk); #1 w_rst = 0; #2;
    chk("w_addr0", w_addr, 32'hFFFF_FFFC);
    chk("w_pc0", w_pc, 32'h0);
    chk("w_flush0", {31'b0, w_flush}, 32'h0);
    chk("w_inst0", w_inst, 32'hFFFF_FFFC ^ 32'hA5A5_A5A5);
    @(posedge clk); #3;
    chk("w_addr1", w_addr, 32'h0);
    chk("w_pc1", w_pc, 32'h4);
    @(posedge clk); #1 w_zero = 0; #2;
    chk("w_wait_req", {31'b0, w_req}, 32'h1);
    chk("w_wait_addr", w_addr, 32'h4);
    chk("w_wait_flush", {31'b0, w_flush}, 32'h1);
    @(posedge clk); #1 w_rst = 1; #2;
    chk("w_rst_req", {31'b0, w_req}, 32'h0);
    chk("w_rst_flush", {31'b0, w_flush}, 32'h1);
    chk("w_rst_inst", w_inst, 32'h0);
    @(posedge clk); #1 w_rst = 0; w_zero = 1; #2;
    chk("w_restart_addr", w_addr, 32'hFFFF_FFFC);
    chk("w_restart_pc", w_pc, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
